// File: rtl/controlador_avanco_if.sv
// Request/strobe bundle between the user/timer side and controlador_avanco.
// master: request source (buttons, timer, counter readback); slave: the controller.
interface controlador_avanco_if;
  logic       req_manual;
  logic       req_auto;
  logic [1:0] estado_contador;
  logic       avanco;
  logic [1:0] concedido;
  logic       ocupado;
  logic [3:0] descartes;

  modport master (
    output req_manual, req_auto, estado_contador,
    input  avanco, concedido, ocupado, descartes
  );

  modport slave (
    input  req_manual, req_auto, estado_contador,
    output avanco, concedido, ocupado, descartes
  );
endinterface

// File: rtl/controlador_avanco.sv
// controlador_avanco: arbitrates manual/auto advance requests for the mode
// counter, issues a one-cycle advance strobe, enforces a lockout window and
// counts lost requests (saturating at 15).
// Optional feature: define AUTO_PENDENTE_EN to hold one valid auto request
// that arrives while busy and serve it when the controller is free again.
//
// state    | meaning
// LIVRE    | idle, accepting requests
// CONCEDE  | advance strobe cycle, lockout counter loads
// BLOQUEIO | lockout window, counter runs down to 0
module controlador_avanco #(
  parameter int LOCKOUT_CYCLES = 8
) (
  input logic                  clock,
  input logic                  reset,
  controlador_avanco_if.slave  bus
);

  typedef enum logic [1:0] {
    LIVRE    = 2'b00,
    CONCEDE  = 2'b01,
    BLOQUEIO = 2'b10
  } estado_t;

  localparam logic [7:0] CARGA = 8'(LOCKOUT_CYCLES - 1);

  estado_t    estado;
  logic [7:0] contador;
  logic       manual_ant;
  logic       avanco_r;
  logic [1:0] concedido_r;
  logic       ocupado_r;
  logic [3:0] descartes_r;

  logic       edge_manual;
  logic       auto_ok;
  logic       livre;
  logic       serve_livre;
  logic       grant_auto;
  logic       drop_manual;
  logic       drop_auto;
  logic [1:0] incremento;
  logic [4:0] soma;

`ifdef AUTO_PENDENTE_EN
  logic pendente;
  logic set_pend;
  logic clr_pend;
  logic drop_pend;
`endif

  // Request qualification, auto grant decision and per-cycle drop count
  always_comb begin
    edge_manual = bus.req_manual & ~manual_ant;
    auto_ok     = (bus.estado_contador == 2'b01) || (bus.estado_contador == 2'b10);
    livre       = (estado == LIVRE);
    // a manual edge in LIVRE wins, so auto can only be taken without one
    serve_livre = livre & ~edge_manual;
    drop_manual = edge_manual & ~livre;
    drop_auto   = 1'b0;
    grant_auto  = 1'b0;
`ifdef AUTO_PENDENTE_EN
    set_pend  = 1'b0;
    clr_pend  = 1'b0;
    drop_pend = 1'b0;
    if (serve_livre && pendente) begin
      clr_pend = 1'b1;
      if (auto_ok) grant_auto = 1'b1;
      else         drop_pend  = 1'b1;
    end
    if (bus.req_auto) begin
      // with the flag occupied a live request has nowhere to go
      if (!auto_ok || pendente) drop_auto  = 1'b1;
      else if (serve_livre)     grant_auto = 1'b1;
      else                      set_pend   = 1'b1;
    end
    incremento = {1'b0, drop_manual} + {1'b0, drop_auto} + {1'b0, drop_pend};
`else
    if (bus.req_auto) begin
      if (auto_ok && serve_livre) grant_auto = 1'b1;
      else                        drop_auto  = 1'b1;
    end
    incremento = {1'b0, drop_manual} + {1'b0, drop_auto};
`endif
    soma = {1'b0, descartes_r} + {3'b000, incremento};
  end

  // Sequencing FSM with registered strobe, grant source, busy flag and drop counter
  always_ff @(posedge clock) begin
    if (!reset) begin
      estado      <= LIVRE;
      contador    <= '0;
      manual_ant  <= 1'b0;
      avanco_r    <= 1'b0;
      concedido_r <= 2'b00;
      ocupado_r   <= 1'b0;
      descartes_r <= 4'd0;
    end else begin
      manual_ant  <= bus.req_manual;
      avanco_r    <= 1'b0;
      descartes_r <= (soma > 5'd15) ? 4'd15 : soma[3:0];
      case (estado)
        LIVRE: begin
          if (edge_manual) begin
            estado      <= CONCEDE;
            concedido_r <= 2'b01;
            avanco_r    <= 1'b1;
            ocupado_r   <= 1'b1;
          end else if (grant_auto) begin
            estado      <= CONCEDE;
            concedido_r <= 2'b10;
            avanco_r    <= 1'b1;
            ocupado_r   <= 1'b1;
          end
        end
        CONCEDE: begin
          estado   <= BLOQUEIO;
          contador <= CARGA;
        end
        BLOQUEIO: begin
          if (contador == 8'd0) begin
            estado    <= LIVRE;
            ocupado_r <= 1'b0;
          end else begin
            contador <= contador - 8'd1;
          end
        end
        default: begin
          estado    <= LIVRE;
          ocupado_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef AUTO_PENDENTE_EN
  // One-deep pending auto request; lost (uncounted) on reset
  always_ff @(posedge clock) begin
    if (!reset)        pendente <= 1'b0;
    else if (clr_pend) pendente <= 1'b0;
    else if (set_pend) pendente <= 1'b1;
  end
`endif

  assign bus.avanco    = avanco_r;
  assign bus.concedido = concedido_r;
  assign bus.ocupado   = ocupado_r;
  assign bus.descartes = descartes_r;

endmodule

// File: tb/tb_controlador_avanco.sv
// Directed self-checking bench for controlador_avanco (LOCKOUT_CYCLES = 8).
// Expected values adapt to whether AUTO_PENDENTE_EN is defined.
module tb_controlador_avanco;

`ifdef AUTO_PENDENTE_EN
  localparam bit PEND = 1'b1;
`else
  localparam bit PEND = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   fails  = 0;
  logic av_prev = 1'b0;

  controlador_avanco_if bus ();

  controlador_avanco #(.LOCKOUT_CYCLES(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       m;
    logic       a;
    logic [1:0] e;
    logic       av;
    logic [1:0] c;
    logic       oc;
    logic [3:0] d;
  } vec_t;

  vec_t tab [13];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // advance one cycle, sample 1 time unit after the edge, and watch for back-to-back strobes
  task automatic step();
    @(posedge clock);
    #1;
    check("no_back_to_back_avanco", 8'(av_prev & bus.avanco), 8'd0);
    av_prev = bus.avanco;
  endtask

  task automatic check_outputs(input string tag, input logic av, input logic [1:0] c,
                               input logic oc, input logic [3:0] d);
    check({tag, "_avanco"},    8'(bus.avanco),    8'(av));
    check({tag, "_concedido"}, 8'(bus.concedido), 8'(c));
    check({tag, "_ocupado"},   8'(bus.ocupado),   8'(oc));
    check({tag, "_descartes"}, 8'(bus.descartes), 8'(d));
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bus.req_manual = 1'b0;
    bus.req_auto = 1'b0;
    bus.estado_contador = 2'b01;
    step();
    step();
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    logic [3:0] d6;
    d6 = PEND ? 4'd2 : 4'd3;

    //           m     a     e      av    c                       oc    d
    tab[0]  = '{1'b0, 1'b0, 2'b01, 1'b0, 2'b00,                  1'b0, 4'd0};
    tab[1]  = '{1'b1, 1'b0, 2'b01, 1'b1, 2'b01,                  1'b1, 4'd0};
    tab[2]  = '{1'b1, 1'b0, 2'b01, 1'b0, 2'b01,                  1'b1, 4'd0};
    tab[3]  = '{1'b0, 1'b0, 2'b01, 1'b0, 2'b01,                  1'b1, 4'd0};
    tab[4]  = '{1'b1, 1'b0, 2'b01, 1'b0, 2'b01,                  1'b1, 4'd1};
    tab[5]  = '{1'b0, 1'b1, 2'b00, 1'b0, 2'b01,                  1'b1, 4'd2};
    tab[6]  = '{1'b0, 1'b1, 2'b01, 1'b0, 2'b01,                  1'b1, d6};
    tab[7]  = '{1'b0, 1'b0, 2'b01, 1'b0, 2'b01,                  1'b1, d6};
    tab[8]  = '{1'b0, 1'b0, 2'b01, 1'b0, 2'b01,                  1'b1, d6};
    tab[9]  = '{1'b0, 1'b0, 2'b01, 1'b0, 2'b01,                  1'b1, d6};
    tab[10] = '{1'b0, 1'b0, 2'b01, 1'b0, 2'b01,                  1'b0, d6};
    tab[11] = '{1'b0, 1'b0, 2'b01, PEND, PEND ? 2'b10 : 2'b01,   PEND, d6};
    tab[12] = '{1'b0, 1'b0, 2'b01, 1'b0, PEND ? 2'b10 : 2'b01,   PEND, d6};

    // reset held low with random inputs
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.req_manual      = 1'($urandom);
      bus.req_auto        = 1'($urandom);
      bus.estado_contador = 2'($urandom);
      step();
      check_outputs("reset_hold", 1'b0, 2'b00, 1'b0, 4'd0);
    end
    bus.req_manual = 1'b0;
    bus.req_auto = 1'b0;
    bus.estado_contador = 2'b01;
    step();
    reset = 1'b1;

    // table: manual grant, lockout drops, auto drops / pending service
    for (int i = 0; i < 13; i++) begin
      bus.req_manual      = tab[i].m;
      bus.req_auto        = tab[i].a;
      bus.estado_contador = tab[i].e;
      step();
      check_outputs($sformatf("vec%0d", i), tab[i].av, tab[i].c, tab[i].oc, tab[i].d);
    end

    // manual edge at N: strobe only at N+1, busy N+1..N+9
    do_reset();
    bus.req_manual = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      step();
      check($sformatf("timing_avanco_%0d", j), 8'(bus.avanco), 8'(j == 1));
      check($sformatf("timing_ocupado_%0d", j), 8'(bus.ocupado), 8'(j <= 9));
    end
    check("timing_concedido", 8'(bus.concedido), 8'd1);
    bus.req_manual = 1'b0;

    // auto in counter state 01 granted, in 00 dropped
    do_reset();
    bus.req_auto = 1'b1;
    step();
    bus.req_auto = 1'b0;
    check_outputs("auto_valid", 1'b1, 2'b10, 1'b1, 4'd0);
    do_reset();
    bus.estado_contador = 2'b00;
    bus.req_auto = 1'b1;
    step();
    bus.req_auto = 1'b0;
    check_outputs("auto_invalid", 1'b0, 2'b00, 1'b0, 4'd1);

    // manual edge and valid auto together in LIVRE: manual wins
    do_reset();
    bus.req_manual = 1'b1;
    bus.req_auto = 1'b1;
    step();
    check("simul_avanco", 8'(bus.avanco), 8'd1);
    check("simul_concedido", 8'(bus.concedido), 8'd1);
    bus.req_auto = 1'b0;
    for (int j = 2; j <= 14; j++) begin
      step();
      check($sformatf("simul_second_avanco_%0d", j), 8'(bus.avanco), 8'(PEND && j == 11));
    end
    check("simul_final_concedido", 8'(bus.concedido), PEND ? 8'd2 : 8'd1);
    check("simul_final_descartes", 8'(bus.descartes), PEND ? 8'd0 : 8'd1);
    bus.req_manual = 1'b0;

    // 20 manual edges 2 cycles apart: grants at offsets 0,10,20,30; 16 drops saturate at 15
    do_reset();
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      bus.req_manual = (k % 2 == 0);
      step();
      if (bus.avanco) cnt++;
    end
    bus.req_manual = 1'b0;
    check("burst_avanco_count", 8'(cnt), 8'd4);
    check("burst_descartes_sat", 8'(bus.descartes), 8'd15);

    // reset during BLOQUEIO with an auto request seen while busy
    do_reset();
    bus.req_manual = 1'b1;
    step();
    bus.req_manual = 1'b0;
    step();
    bus.req_auto = 1'b1;
    step();
    bus.req_auto = 1'b0;
    step();
    check("pre_reset_ocupado", 8'(bus.ocupado), 8'd1);
    reset = 1'b0;
    step();
    check_outputs("mid_reset", 1'b0, 2'b00, 1'b0, 4'd0);
    reset = 1'b1;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (bus.avanco) cnt++;
    end
    check("post_reset_avanco_count", 8'(cnt), 8'd0);
    check("post_reset_descartes", 8'(bus.descartes), 8'd0);

    // held button: exactly one request
    do_reset();
    bus.req_manual = 1'b1;
    cnt = 0;
    for (int k = 0; k < 50; k++) begin
      step();
      if (bus.avanco) cnt++;
    end
    bus.req_manual = 1'b0;
    check("held_avanco_count", 8'(cnt), 8'd1);
    check("held_descartes", 8'(bus.descartes), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
